// File: rtl/merge_axil_regfile_if.sv
// rtl/merge_axil_regfile_if.sv - AXI4-Lite slave bus bundle for merge_axil_regfile
//
// Purpose: groups the five AXI4-Lite channels into one port.
// Ports (modport slave, as seen by the register file):
//   AW: S_AXI_AWADDR/AWPROT/AWVALID in, S_AXI_AWREADY out
//   W : S_AXI_WDATA/WSTRB/WVALID in,    S_AXI_WREADY out
//   B : S_AXI_BREADY in,                S_AXI_BRESP/BVALID out
//   AR: S_AXI_ARADDR/ARPROT/ARVALID in, S_AXI_ARREADY out
//   R : S_AXI_RREADY in,                S_AXI_RDATA/RRESP/RVALID out
interface merge_axil_regfile_if #(
  parameter int DW = 32,
  parameter int AW = 8
);
  logic [AW-1:0]   S_AXI_AWADDR;
  logic [2:0]      S_AXI_AWPROT;
  logic            S_AXI_AWVALID;
  logic            S_AXI_AWREADY;
  logic [DW-1:0]   S_AXI_WDATA;
  logic [DW/8-1:0] S_AXI_WSTRB;
  logic            S_AXI_WVALID;
  logic            S_AXI_WREADY;
  logic [1:0]      S_AXI_BRESP;
  logic            S_AXI_BVALID;
  logic            S_AXI_BREADY;
  logic [AW-1:0]   S_AXI_ARADDR;
  logic [2:0]      S_AXI_ARPROT;
  logic            S_AXI_ARVALID;
  logic            S_AXI_ARREADY;
  logic [DW-1:0]   S_AXI_RDATA;
  logic [1:0]      S_AXI_RRESP;
  logic            S_AXI_RVALID;
  logic            S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );
endinterface

// File: rtl/merge_axil_regfile.sv
// rtl/merge_axil_regfile.sv - AXI4-Lite register file with optional W1C status register
//
// Purpose: NUM_REGS x DW register file behind an AXI4-Lite slave, one write and
// one read outstanding, independent write/read FSMs.
// Ports:
//   S_AXI_ACLK     clock, rising edge
//   S_AXI_ARESETN  asynchronous active-low reset
//   s_axi          AXI4-Lite slave bundle (merge_axil_regfile_if.slave)
//   reg_q          flattened register contents, register k at [k*DW +: DW]
//   reg_wr_pulse   one-cycle pulse per register on the cycle it is written
//   irq_set        per-bit set requests for the status register
//   irq            OR of the status register bits
// Option: MERGE_AXIL_REGFILE_W1C_EN turns register NUM_REGS-1 into a
//   set-by-hardware / write-1-to-clear status register driving irq.
module merge_axil_regfile #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 8,
  parameter int NUM_REGS           = 16
) (
  input  logic                                     S_AXI_ACLK,
  input  logic                                     S_AXI_ARESETN,
  merge_axil_regfile_if.slave                      s_axi,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0]   reg_q,
  output logic [NUM_REGS-1:0]                      reg_wr_pulse,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]            irq_set,
  output logic                                     irq
);
  localparam int DW       = C_S_AXI_DATA_WIDTH;
  localparam int AW       = C_S_AXI_ADDR_WIDTH;
  localparam int STRB_W   = DW / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = $clog2(NUM_REGS);

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  // Any address bit above the register index field marks the access out of range.
  function automatic logic addr_oor(input logic [AW-1:0] a);
    return (a >> (ADDR_LSB + IDX_W)) != '0;
  endfunction

  w_state_t               w_state_q, w_state_d;
  r_state_t               r_state_q, r_state_d;
  logic                   aw_held_q, aw_held_d;
  logic                   w_held_q, w_held_d;
  logic [AW-1:0]          awaddr_q, awaddr_d;
  logic [DW-1:0]          wdata_q, wdata_d;
  logic [STRB_W-1:0]      wstrb_q, wstrb_d;
  logic                   awready_q, awready_d;
  logic                   wready_q, wready_d;
  logic                   bvalid_q, bvalid_d;
  logic [1:0]             bresp_q, bresp_d;
  logic                   arready_q, arready_d;
  logic                   rvalid_q, rvalid_d;
  logic [1:0]             rresp_q, rresp_d;
  logic [DW-1:0]          rdata_q, rdata_d;
  logic [NUM_REGS*DW-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]    pulse_q, pulse_d;
  logic                   wr_en;
  logic [IDX_W-1:0]       wr_idx;
  logic [DW-1:0]          wr_mask;
  logic                   aw_fire, w_fire, ar_fire;
  logic [IDX_W-1:0]       ar_idx;

  assign aw_fire = s_axi.S_AXI_AWVALID && awready_q;
  assign w_fire  = s_axi.S_AXI_WVALID && wready_q;
  assign ar_fire = s_axi.S_AXI_ARVALID && arready_q;
  assign ar_idx  = s_axi.S_AXI_ARADDR[ADDR_LSB +: IDX_W];

  assign s_axi.S_AXI_AWREADY = awready_q;
  assign s_axi.S_AXI_WREADY  = wready_q;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_ARREADY = arready_q;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign reg_q               = regs_q;
  assign reg_wr_pulse        = pulse_q;

  // Write FSM. AW and W are captured independently; the commit happens on the
  // edge where the second of the two arrives, using the bus value directly so
  // BVALID rises one cycle after the later handshake.
  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    wr_en     = 1'b0;
    wr_idx    = '0;
    pulse_d   = '0;
    case (w_state_q)
      W_IDLE: begin
        if (aw_fire) begin
          aw_held_d = 1'b1;
          awaddr_d  = s_axi.S_AXI_AWADDR;
        end
        if (w_fire) begin
          w_held_d = 1'b1;
          wdata_d  = s_axi.S_AXI_WDATA;
          wstrb_d  = s_axi.S_AXI_WSTRB;
        end
        if (aw_held_d && w_held_d) begin
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          awready_d = 1'b0;
          wready_d  = 1'b0;
          bvalid_d  = 1'b1;
          w_state_d = W_RESP;
          wr_idx    = awaddr_d[ADDR_LSB +: IDX_W];
          if (addr_oor(awaddr_d)) begin
            bresp_d = 2'b10;
          end else begin
            bresp_d         = 2'b00;
            wr_en           = 1'b1;
            pulse_d[wr_idx] = 1'b1;
          end
        end else begin
          // Also raises the ready lines on the first cycle out of reset.
          awready_d = !aw_held_d;
          wready_d  = !w_held_d;
        end
      end
      W_RESP: begin
        if (s_axi.S_AXI_BREADY) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          w_state_d = W_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    wr_mask = '0;
    for (int b = 0; b < STRB_W; b++) begin
      wr_mask[b*8 +: 8] = {8{wstrb_d[b]}};
    end
  end

`ifdef MERGE_AXIL_REGFILE_W1C_EN
  localparam int ST_LSB = (NUM_REGS - 1) * DW;
  logic [DW-1:0] status_clr;
  logic          irq_q;

  // Status register ignores the ordinary write path: strobed 1s clear, and
  // hardware sets are applied last so a coincident set wins.
  always_comb begin
    regs_d     = regs_q;
    status_clr = '0;
    if (wr_en) begin
      regs_d[int'(wr_idx)*DW +: DW] = (regs_q[int'(wr_idx)*DW +: DW] & ~wr_mask)
                                    | (wdata_d & wr_mask);
      if (wr_idx == IDX_W'(NUM_REGS - 1)) status_clr = wdata_d & wr_mask;
    end
    regs_d[ST_LSB +: DW] = (regs_q[ST_LSB +: DW] & ~status_clr) | irq_set;
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) irq_q <= 1'b0;
    else                irq_q <= |regs_d[ST_LSB +: DW];
  end

  assign irq = irq_q;

  logic unused_ok;
  assign unused_ok = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT};
`else
  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[int'(wr_idx)*DW +: DW] = (regs_q[int'(wr_idx)*DW +: DW] & ~wr_mask)
                                    | (wdata_d & wr_mask);
    end
  end

  assign irq = 1'b0;

  logic unused_ok;
  assign unused_ok = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT, irq_set};
`endif

  // Read FSM. Data is sampled from regs_q at the AR edge, so a write
  // committing on the same edge is not yet visible.
  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (ar_fire) begin
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          r_state_d = R_DATA;
          if (addr_oor(s_axi.S_AXI_ARADDR)) begin
            rresp_d = 2'b10;
            rdata_d = '0;
          end else begin
            rresp_d = 2'b00;
            rdata_d = regs_q[int'(ar_idx)*DW +: DW];
          end
        end
      end
      R_DATA: begin
        if (s_axi.S_AXI_RREADY) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          r_state_d = R_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= 2'b00;
      rdata_q   <= '0;
      regs_q    <= '0;
      pulse_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      regs_q    <= regs_d;
      pulse_q   <= pulse_d;
    end
  end
endmodule

// File: doc/merge_axil_regfile.md
MERGE_AXIL_REGFILE -- requirements
Module: merge_axil_regfile

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, data width in bits; legal values are 32 and 64.
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 8, byte-address width; must be >= ADDR_LSB+log2(NUM_REGS).
REQ-003 SHALL have parameter NUM_REGS, default 16, register count; power of two, 4..64.
REQ-004 S_AXI_ACLK  in  1  sole clock; all logic on rising edge.
REQ-005 S_AXI_ARESETN  in  1  reset, asynchronous assert, active-low.
REQ-006 S_AXI_AWADDR/AWPROT/AWVALID in, AWREADY out  ADDR_W/3/1/1  write-address channel; AWPROT ignored.
REQ-007 S_AXI_WDATA/WSTRB/WVALID in, WREADY out  DW/DW/8/1/1  write-data channel.
REQ-008 S_AXI_BRESP/BVALID out, BREADY in  2/1/1  write-response channel.
REQ-009 S_AXI_ARADDR/ARPROT/ARVALID in, ARREADY out  ADDR_W/3/1/1  read-address channel; ARPROT ignored.
REQ-010 S_AXI_RDATA/RRESP/RVALID out, RREADY in  DW/2/1/1  read-data channel.
REQ-011 reg_q  out  NUM_REGS*DW  flattened register contents, register k at bits [k*DW +: DW].
REQ-012 reg_wr_pulse  out  NUM_REGS  one-cycle pulse on the cycle register k is written.
REQ-013 irq_set  in  DW  per-bit set requests for the status register (used only with macro, REQ-031).
REQ-014 irq  out  1  interrupt, OR of status register bits (REQ-031).

Function
REQ-015 ADDR_LSB = log2(DW/8); register index = addr[ADDR_LSB+log2(NUM_REGS)-1 : ADDR_LSB]; addr bits below ADDR_LSB ignored.
REQ-016 Address with any nonzero bit above the index field SHALL be out-of-range: write discarded, BRESP=2'b10 (SLVERR); read RDATA=0, RRESP=2'b10.
REQ-017 Write FSM states W_IDLE, W_RESP. In W_IDLE, AWREADY high until AW captured, WREADY high until W captured, independently, in either order or same cycle.
REQ-018 Clock edge after both AW and W are held: register updated, reg_wr_pulse[k]=1 for one cycle, BVALID=1, BRESP=OKAY or SLVERR, state W_RESP.
REQ-019 In W_RESP, AWREADY=WREADY=0; BVALID/BRESP held stable until BREADY; on BVALID&BREADY return to W_IDLE, ready lines high next cycle.
REQ-020 Byte lane b of register updated only when WSTRB[b]=1; WSTRB=0 performs no data change but still pulses reg_wr_pulse and returns OKAY.
REQ-021 Read FSM states R_IDLE, R_DATA. In R_IDLE ARREADY=1; on AR handshake RDATA/RRESP registered at that edge, RVALID=1 next cycle, ARREADY=0.
REQ-022 In R_DATA RDATA/RRESP/RVALID stable until RREADY; on RVALID&RREADY return to R_IDLE.
REQ-023 Read and write channels independent; read handshake on same edge as write commit to same register returns pre-write value.
REQ-024 At most one outstanding write and one outstanding read; no ID, no bursts.
REQ-025 Throughput: one write per 2 cycles, one read per 2 cycles, with READY/B/R ready held high.

Reset
REQ-026 While S_AXI_ARESETN=0: all registers 0, FSMs in W_IDLE/R_IDLE, AWREADY=WREADY=ARREADY=0, BVALID=RVALID=0, BRESP=RRESP=0, RDATA=0, reg_wr_pulse=0, irq=0.
REQ-027 First cycle after deassertion (sampled synchronously) AWREADY=WREADY=ARREADY=1.
REQ-028 Reset mid-transaction SHALL abandon it: pending AW/W discarded, BVALID/RVALID drop immediately, no register write.

Configuration
REQ-029 Macro MERGE_AXIL_REGFILE_W1C_EN selects status-register behaviour for register NUM_REGS-1.
REQ-030 Without macro: register NUM_REGS-1 is ordinary read/write; irq_set ignored; irq tied 0.
REQ-031 With macro: each cycle bit i set when irq_set[i]=1; AXI write of 1 to a strobed bit clears it, 0 leaves it; set and clear same cycle -> set wins; irq = |reg[NUM_REGS-1], registered.

Verification
REQ-032 Write 0x1,0x2,0x3,0x4 to 0x00,0x04,0x08,0x0C, read back -> same data, RRESP=OKAY, BVALID one cycle after later of AW/W.
REQ-033 W presented 3 cycles before AW to 0x10, data 0xA5A5A5A5 -> single commit after AW, BRESP=OKAY, reg_wr_pulse[4] exactly one cycle.
REQ-034 Reg 2 = 0xFFFFFFFF, write 0x00000000 with WSTRB=4'b0101 -> read 0xFF00FF00.
REQ-035 NUM_REGS=16, write to 0x40 and read 0x40 -> BRESP=RRESP=2'b10, RDATA=0, reg_q unchanged.
REQ-036 BREADY/RREADY held low 5 cycles -> BVALID/RVALID, BRESP, RDATA stable, all READY low; reset asserted in cycle 3 -> all outputs 0 immediately.
REQ-037 With macro: irq_set=0x5 one cycle -> irq=1; write 0x4 to status -> reads 0x1, irq=1; write 0x1 coincident with irq_set=0x1 -> bit 0 stays 1.
